flash_rate_engine: RTL and testbench
====================================

Name: flash_rate_engine

Overview:
Consumer end of the master FSM interface. It takes the 3-bit mode code and the single-cycle shift pulses from the master FSM, and holds the flash-rate state for the two flash modes. It generates the actual LED drive waveform and sits between the master FSM and the board LED pin.

Parameters:
TICKS_PER_EIGHTH, 12_500_000, clk cycles per 1/8 s base tick (100 MHz clock); benches use 2
PRESCALE_W, $clog2(TICKS_PER_EIGHTH), prescaler counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mode  input  3  mode code from master FSM
shift_left1  input  1  1-cycle pulse: FLASH1 slower (double phase length)
shift_right1  input  1  1-cycle pulse: FLASH1 faster (halve phase length)
shift_left2  input  1  1-cycle pulse: FLASH2 slower
shift_right2  input  1  1-cycle pulse: FLASH2 faster
led  output  1  registered LED drive
rate1  output  2  FLASH1 exponent e1; phase = 8<<e1 eighths (1, 2, 4, 8 s)
rate2  output  2  FLASH2 exponent e2; phase = 8>>e2 eighths (1, 1/2, 1/4, 1/8 s)

Behaviour:
- One clock; reset is asynchronous and active-high; port names are clk and reset.
- Reset, whenever asserted, including mid-flash: led=0, rate1=0, rate2=0, prescaler=0, phase counter=0.
- Mode codes:
  - 0 OFF1, 1 ON, 2 OFF2, 3 FLASH1, 4 OFF3, 5 FLASH2.
  - Codes 6 and 7 are treated as OFF.
- Rate registers:
  - shift_left1 increments e1, saturating at 3; shift_right1 decrements e1, saturating at 0.
  - shift_right2 increments e2, saturating at 3; shift_left2 decrements e2, saturating at 0.
  - Both pulses of a pair high in the same cycle: no change.
  - Pulses are accepted in any mode.
  - Rates are retained across mode changes and cleared only by reset.
- Eighth-tick prescaler: counts 0..TICKS_PER_EIGHTH-1. The tick is asserted in the cycle the count equals TICKS_PER_EIGHTH-1, then the count wraps.
- Phase counter:
  - 7 bits; counts ticks only in FLASH modes.
  - Phase length L = 8<<e1 in FLASH1, 8>>e2 in FLASH2.
  - On a tick with count >= L-1: led toggles and count clears. Otherwise count increments on each tick.
- LED output (registered, latency 1 cycle from a mode change):
  - OFF modes: led=0.
  - ON: led=1.
  - FLASH: waveform as described under the phase counter.
- Flash entry: when mode changes to 3 or 5 from any other code, including 3<->5:
  - led=1 on the next edge;
  - prescaler and phase counter cleared;
  - first full phase is on.
- Rate change mid-phase: the new L applies immediately. Because of the >= compare, if count already exceeds the new L-1, the toggle happens at the next tick.
- Leaving a flash mode clears the phase counter and prescaler.

Optional Feature:
Macro PHASE_RESTART_EN.
- Defined: any accepted rate change (a pulse that actually changes e1 or e2) in the currently active flash mode clears the prescaler and phase counter in that cycle. led is left unchanged.
- Undefined: the counter is kept and the >= compare rule above applies.

Decomposition:
- Package flash_pkg: mode code localparams (MODE_OFF1..MODE_FLASH2), RATE_MAX=3, EIGHTHS_PER_SEC=8, PHASE_CNT_W=7.
- One sub-module, eighth_tick_gen: prescaler with parameter TICKS_PER_EIGHTH and inputs clk, reset, clear. It outputs tick.

Test Plan:
All scenarios use TICKS_PER_EIGHTH=2.
- Reset: assert reset mid-flash with rate1=2 -> led=0, rate1=0, rate2=0 immediately, without waiting for a clock edge.
- FLASH1 default: mode=3, rates 0 -> led=1 one cycle after entry; led 1 for 16 clk, then 0 for 16 clk, repeating.
- FLASH1 slower: four shift_left1 pulses -> rate1 = 1, 2, 3, 3; phase = 128 clk. Then shift_right1 ×4 -> rate1 = 0, and a further pulse keeps it at 0.
- FLASH2 faster: mode=5, three shift_right2 pulses -> rate2=3, led toggles every 2 clk. shift_left2 at rate2=0 keeps it at 0.
- Static modes: mode=1 -> led=1 next cycle; mode=4 -> led=0; mode=7 -> led=0. Shift pulses in OFF1 still update rate1/rate2.
- Corner cases:
  - shift_left1 and shift_right1 high in the same cycle -> rate1 unchanged.
  - FLASH1 at e1=3 with count=40, then shift_right1 ×2 (L=16) -> toggle on the next tick. With PHASE_RESTART_EN: toggle 16 ticks after the last pulse.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared mode codes and widths for the flash-rate engine.
package flash_pkg;
    localparam logic [2:0] MODE_OFF1   = 3'd0;
    localparam logic [2:0] MODE_ON     = 3'd1;
    localparam logic [2:0] MODE_OFF2   = 3'd2;
    localparam logic [2:0] MODE_FLASH1 = 3'd3;
    localparam logic [2:0] MODE_OFF3   = 3'd4;
    localparam logic [2:0] MODE_FLASH2 = 3'd5;

    localparam logic [1:0] RATE_MAX        = 2'd3;
    localparam int         EIGHTHS_PER_SEC = 8;
    localparam int         PHASE_CNT_W     = 7;

    function automatic logic is_flash(input logic [2:0] m);
        return (m == MODE_FLASH1) || (m == MODE_FLASH2);
    endfunction
endpackage

// File: rtl/eighth_tick_gen.sv
// Prescaler producing a one-cycle tick every TICKS_PER_EIGHTH clocks.
module eighth_tick_gen #(
    parameter int TICKS_PER_EIGHTH = 12_500_000,
    parameter int PRESCALE_W       = (TICKS_PER_EIGHTH > 1) ? $clog2(TICKS_PER_EIGHTH) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(TICKS_PER_EIGHTH - 1);

    logic [PRESCALE_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end
endmodule

// File: rtl/flash_rate_engine.sv
// LED driver for the master FSM modes; holds the two flash-rate exponents.
// Build option PHASE_RESTART_EN restarts the current phase on an accepted rate change.
module flash_rate_engine
    import flash_pkg::*;
#(
    parameter int TICKS_PER_EIGHTH = 12_500_000,
    parameter int PRESCALE_W       = (TICKS_PER_EIGHTH > 1) ? $clog2(TICKS_PER_EIGHTH) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       shift_left1,
    input  logic       shift_right1,
    input  logic       shift_left2,
    input  logic       shift_right2,
    output logic       led,
    output logic [1:0] rate1,
    output logic [1:0] rate2
);
    logic [2:0]             prev_mode;
    logic [PHASE_CNT_W-1:0] phase, phase_n, limit;
    logic [1:0]             rate1_n, rate2_n;
    logic                   led_n, in_flash, entry, restart, clear, tick;

    eighth_tick_gen #(
        .TICKS_PER_EIGHTH(TICKS_PER_EIGHTH),
        .PRESCALE_W      (PRESCALE_W)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    always_comb begin
        in_flash = is_flash(mode);
        entry    = in_flash && (mode != prev_mode);

        rate1_n = rate1;
        if (shift_left1 && !shift_right1 && rate1 != RATE_MAX)
            rate1_n = rate1 + 1'b1;
        else if (shift_right1 && !shift_left1 && rate1 != 2'd0)
            rate1_n = rate1 - 1'b1;

        rate2_n = rate2;
        if (shift_right2 && !shift_left2 && rate2 != RATE_MAX)
            rate2_n = rate2 + 1'b1;
        else if (shift_left2 && !shift_right2 && rate2 != 2'd0)
            rate2_n = rate2 - 1'b1;

`ifdef PHASE_RESTART_EN
        restart = ((mode == MODE_FLASH1) && (rate1_n != rate1)) ||
                  ((mode == MODE_FLASH2) && (rate2_n != rate2));
`else
        restart = 1'b0;
`endif

        // Compare limit is L-1 taken from the registered rate, so a rate
        // drop below the current count toggles on the very next tick.
        if (mode == MODE_FLASH1)
            limit = (PHASE_CNT_W'(EIGHTHS_PER_SEC) << rate1) - PHASE_CNT_W'(1);
        else
            limit = (PHASE_CNT_W'(EIGHTHS_PER_SEC) >> rate2) - PHASE_CNT_W'(1);

        clear = !in_flash || entry || restart;

        led_n = led;
        unique case (mode)
            MODE_ON:                  led_n = 1'b1;
            MODE_FLASH1, MODE_FLASH2: begin
                if (entry)
                    led_n = 1'b1;
                else if (tick && !restart && phase >= limit)
                    led_n = ~led;
            end
            MODE_OFF1, MODE_OFF2, MODE_OFF3: led_n = 1'b0;
            default:                  led_n = 1'b0;
        endcase

        phase_n = phase;
        if (clear)
            phase_n = '0;
        else if (tick)
            phase_n = (phase >= limit) ? '0 : phase + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led       <= 1'b0;
            rate1     <= 2'd0;
            rate2     <= 2'd0;
            phase     <= '0;
            prev_mode <= MODE_OFF1;
        end else begin
            led       <= led_n;
            rate1     <= rate1_n;
            rate2     <= rate2_n;
            phase     <= phase_n;
            prev_mode <= mode;
        end
    end
endmodule

// File: tb/tb_flash_rate_engine.sv
// Directed scoreboard bench for flash_rate_engine with TICKS_PER_EIGHTH=2.
module tb_flash_rate_engine;
    localparam int LED = 0, R1 = 1, R2 = 2;
    localparam logic [3:0] SL1 = 4'b0001, SR1 = 4'b0010, SL2 = 4'b0100, SR2 = 4'b1000;

    typedef struct {
        int         cyc;
        int         sig;
        logic [1:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode;
    logic [3:0] sh;
    logic       led;
    logic [1:0] rate1, rate2;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       done = 1'b0;
    exp_t       sbq[$];

    flash_rate_engine #(.TICKS_PER_EIGHTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .shift_left1 (sh[0]),
        .shift_right1(sh[1]),
        .shift_left2 (sh[2]),
        .shift_right2(sh[3]),
        .led         (led),
        .rate1       (rate1),
        .rate2       (rate2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic expect_at(input int at, input int sig, input logic [1:0] val, input string name);
        exp_t e;
        e.cyc = at; e.sig = sig; e.val = val; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] p);
        sh = p;
        step(1);
        sh = 4'b0000;
    endtask

    // Monitor: compares every queued expectation due at this cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].cyc == cyc) begin
                logic [1:0] act;
                case (sbq[i].sig)
                    LED:     act = {1'b0, led};
                    R1:      act = rate1;
                    default: act = rate2;
                endcase
                checks++;
                if (act !== sbq[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%0d expected=%0d", sbq[i].name, cyc, act, sbq[i].val);
                end
                sbq.delete(i);
            end else begin
                i++;
            end
        end
        if (done) begin
            foreach (sbq[j]) begin
                checks++;
                errors++;
                $display("FAIL %s never compared (due cyc=%0d, expected=%0d)", sbq[j].name, sbq[j].cyc, sbq[j].val);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        int k;
        reset = 1'b1;
        mode  = 3'd0;
        sh    = 4'b0000;
        expect_at(1, LED, 2'd0, "rst_led");
        expect_at(1, R1,  2'd0, "rst_rate1");
        expect_at(1, R2,  2'd0, "rst_rate2");
        step(2);
        reset = 1'b0;

        // FLASH1 at e1=0: 16 clk on, 16 clk off
        k = cyc;
        expect_at(k,    LED, 2'd0, "f1_pre");
        expect_at(k+1,  LED, 2'd1, "f1_on_first");
        expect_at(k+16, LED, 2'd1, "f1_on_last");
        expect_at(k+17, LED, 2'd0, "f1_off_first");
        expect_at(k+32, LED, 2'd0, "f1_off_last");
        expect_at(k+33, LED, 2'd1, "f1_on_again");
        mode = 3'd3;
        step(34);
        expect_at(cyc+1, LED, 2'd0, "off1_led");
        mode = 3'd0;
        step(1);

        // Rate pulses in OFF1
        for (int i = 1; i <= 4; i++) begin
            expect_at(cyc+1, R1, (i > 3) ? 2'd3 : 2'(i), "r1_up");
            pulse(SL1);
        end
        expect_at(cyc+1, R1, 2'd3, "r1_both_high");
        pulse(SL1 | SR1);
        expect_at(cyc+1, R2, 2'd1, "r2_up_off1");
        pulse(SR2);
        expect_at(cyc+1, R2, 2'd0, "r2_down_off1");
        pulse(SL2);
        expect_at(cyc+1, R2, 2'd0, "r2_sat0_off1");
        pulse(SL2);

        // FLASH1 at e1=3: 128 clk phase
        k = cyc;
        expect_at(k+1,   LED, 2'd1, "f1s_on_first");
        expect_at(k+128, LED, 2'd1, "f1s_on_last");
        expect_at(k+129, LED, 2'd0, "f1s_off_first");
        mode = 3'd3;
        step(130);
        mode = 3'd0;
        step(1);

        for (int i = 1; i <= 4; i++) begin
            expect_at(cyc+1, R1, (i >= 3) ? 2'd0 : 2'(3 - i), "r1_down");
            pulse(SR1);
        end
        expect_at(cyc+1, R1, 2'd0, "r1_sat0");
        pulse(SR1);
        for (int i = 1; i <= 3; i++) begin
            expect_at(cyc+1, R1, 2'(i), "r1_up_again");
            pulse(SL1);
        end

        // Rate drop while count=40 at e1=3
        k = cyc;
        expect_at(k+82, LED, 2'd1, "corner_led_before");
        expect_at(k+82, R1,  2'd2, "corner_rate_mid");
        expect_at(k+83, R1,  2'd1, "corner_rate_end");
`ifdef PHASE_RESTART_EN
        expect_at(k+83,  LED, 2'd1, "corner_led_kept");
        expect_at(k+114, LED, 2'd1, "corner_led_pre_toggle");
        expect_at(k+115, LED, 2'd0, "corner_led_toggle");
`else
        expect_at(k+83,  LED, 2'd0, "corner_led_toggle");
        expect_at(k+114, LED, 2'd0, "corner_led_short_phase");
        expect_at(k+115, LED, 2'd1, "corner_led_next_toggle");
`endif
        mode = 3'd3;
        step(81);
        sh = SR1;
        step(2);
        sh = 4'b0000;
        step(37);

        // FLASH1 -> FLASH2 re-entry, then speed up
        expect_at(cyc+1, LED, 2'd1, "f2_entry_from_f1");
        mode = 3'd5;
        step(1);
        for (int i = 1; i <= 3; i++) begin
            expect_at(cyc+1, R2, 2'(i), "r2_up_f2");
            pulse(SR2);
        end
        expect_at(cyc+1, LED, 2'd0, "off3_led");
        mode = 3'd4;
        step(2);
        k = cyc;
        expect_at(k+1, LED, 2'd1, "f2_fast_on1");
        expect_at(k+2, LED, 2'd1, "f2_fast_on2");
        expect_at(k+3, LED, 2'd0, "f2_fast_off1");
        expect_at(k+4, LED, 2'd0, "f2_fast_off2");
        expect_at(k+5, LED, 2'd1, "f2_fast_on3");
        mode = 3'd5;
        step(6);

        // Static modes
        expect_at(cyc+1, LED, 2'd1, "on_led");
        mode = 3'd1;
        step(1);
        for (int i = 1; i <= 4; i++) begin
            expect_at(cyc+1, R2, (i >= 3) ? 2'd0 : 2'(3 - i), "r2_down_on");
            pulse(SL2);
        end
        expect_at(cyc+1, LED, 2'd0, "code7_led");
        mode = 3'd7;
        step(2);

        // Asynchronous reset mid-flash
        expect_at(cyc+1, R2, 2'd1, "r2_pre_rst");
        pulse(SR2);
        mode = 3'd3;
        step(3);
        expect_at(cyc+1, R1, 2'd2, "r1_pre_rst");
        pulse(SL1);
        expect_at(cyc, LED, 2'd1, "led_pre_rst");
        step(1);
        reset = 1'b1;
        expect_at(cyc, LED, 2'd0, "async_rst_led");
        expect_at(cyc, R1,  2'd0, "async_rst_rate1");
        expect_at(cyc, R2,  2'd0, "async_rst_rate2");
        step(2);
        reset = 1'b0;
        mode  = 3'd0;
        step(2);
        done = 1'b1;
    end
endmodule
